fc_argmax_8_16: RTL and testbench

//  Downstream stage of a standalone FC layer. Consumes the layer's M-element signed result stream

---
 rtl/fc_pkg.sv | 15 +
 rtl/fc_argmax_cmp.sv | 29 ++
 rtl/fc_argmax_8_16.sv | 108 ++++++++++
 tb/tb_fc_argmax_8_16.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the FC argmax stage.
package fc_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } argmax_state_t;

    localparam int T_DEF = 16;

    function automatic int idx_w(input int m);
        return $clog2(m);
    endfunction

endpackage

// File: rtl/fc_argmax_cmp.sv
// Combinational running-max step: keeps the current best unless the candidate is strictly larger
// (or is the first element of a vector).
module fc_argmax_cmp #(
    parameter int T  = 16,
    parameter int IW = 3
) (
    input  logic signed [T-1:0]  cand_val,
    input  logic        [IW-1:0] cand_idx,
    input  logic signed [T-1:0]  best_val,
    input  logic        [IW-1:0] best_idx,
    input  logic                 first,
    output logic signed [T-1:0]  nxt_val,
    output logic        [IW-1:0] nxt_idx
);

    // Strict compare so ties keep the lowest index.
    always_comb begin
        nxt_val = best_val;
        nxt_idx = best_idx;
        if (first || (cand_val > best_val)) begin
            nxt_val = cand_val;
            nxt_idx = cand_idx;
        end else begin
            nxt_val = best_val;
            nxt_idx = best_idx;
        end
    end

endmodule

// File: rtl/fc_argmax_8_16.sv
// Argmax over an M-element signed stream, one index result per vector.
// Optional output_max port enabled by defining FC_ARGMAX_VALUE_EN.
module fc_argmax_8_16
    import fc_pkg::*;
#(
    parameter int M = 8,
    parameter int T = T_DEF,
    localparam int IW = idx_w(M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                input_valid,
    output logic                input_ready,
    input  logic signed [T-1:0] input_data,
    output logic                output_valid,
    input  logic                output_ready,
    output logic [IW-1:0]       output_idx
`ifdef FC_ARGMAX_VALUE_EN
    ,
    output logic signed [T-1:0] output_max
`endif
);

    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    argmax_state_t       state_q, state_d;
    logic [IW-1:0]       count_q, count_d;
    logic signed [T-1:0] best_val_q, best_val_d;
    logic [IW-1:0]       best_idx_q, best_idx_d;

    logic                accept_s;
    logic signed [T-1:0] cmp_val_s;
    logic [IW-1:0]       cmp_idx_s;

    assign accept_s = input_valid && (state_q == COLLECT);

    fc_argmax_cmp #(
        .T  (T),
        .IW (IW)
    ) u_cmp (
        .cand_val (input_data),
        .cand_idx (count_q),
        .best_val (best_val_q),
        .best_idx (best_idx_q),
        .first    (count_q == {IW{1'b0}}),
        .nxt_val  (cmp_val_s),
        .nxt_idx  (cmp_idx_s)
    );

    // Next-state logic: collect elements, then hold the result until downstream takes it.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        case (state_q)
            COLLECT: begin
                if (accept_s) begin
                    best_val_d = cmp_val_s;
                    best_idx_d = cmp_idx_s;
                    if (count_q == LAST_IDX) begin
                        count_d = {IW{1'b0}};
                        state_d = EMIT;
                    end else begin
                        count_d = count_q + {{(IW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            EMIT: begin
                if (output_ready) begin
                    state_d = COLLECT;
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = {IW{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= COLLECT;
            count_q    <= {IW{1'b0}};
            best_val_q <= {T{1'b0}};
            best_idx_q <= {IW{1'b0}};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    // Handshake flags come straight from the state register, no path from inputs.
    assign input_ready  = (state_q == COLLECT);
    assign output_valid = (state_q == EMIT);
    assign output_idx   = best_idx_q;
`ifdef FC_ARGMAX_VALUE_EN
    assign output_max   = best_val_q;
`endif

endmodule

// File: tb/tb_fc_argmax_8_16.sv
// Scoreboard bench for fc_argmax_8_16: driver pushes expected results, negedge monitor pops on handshake.
module tb_fc_argmax_8_16;

    typedef logic signed [15:0] vec_t [8];
    typedef struct packed {
        logic [2:0]         idx;
        logic signed [15:0] mx;
    } exp_t;

    logic               clk;
    logic               reset;
    logic               input_valid;
    logic               input_ready;
    logic signed [15:0] input_data;
    logic               output_valid;
    logic               output_ready;
    logic [2:0]         output_idx;
`ifdef FC_ARGMAX_VALUE_EN
    logic signed [15:0] output_max;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    fc_argmax_8_16 dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_idx   (output_idx)
`ifdef FC_ARGMAX_VALUE_EN
        ,
        .output_max   (output_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [2:0] idx, input logic signed [15:0] mx);
        exp_t e;
        e.idx = idx;
        e.mx  = mx;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every accepted result against the scoreboard head.
    always @(negedge clk) begin
        if (reset && output_valid && output_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'sd1, 32'sd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_idx", {29'd0, output_idx}, {29'd0, e.idx});
`ifdef FC_ARGMAX_VALUE_EN
                chk("result_max", 32'(output_max), 32'(e.mx));
`endif
            end
        end
    end

    // Drive n elements; optional one-cycle bubble before each element after the first.
    task automatic send_vec(input vec_t v, input int n, input bit bub, output int edges);
        logic rdy;
        logic acc;
        edges = 0;
        acc   = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (bub && i > 0) begin
                input_valid = 1'b0;
                @(posedge clk); #1;
                edges++;
            end
            input_valid = 1'b1;
            input_data  = v[i];
            acc = 1'b0;
            while (!acc && edges < 200) begin
                rdy = input_ready;
                @(posedge clk); #1;
                edges++;
                acc = rdy;
            end
        end
        input_valid = 1'b0;
        chk("elements_accepted", {31'd0, acc}, 32'sd1);
    endtask

    initial begin
        vec_t v1, v_neg5, v_ext, v_tie, v_part, v_six;
        int   edges;

        v1     = '{-16'sd61, 16'sd105, -16'sd75, -16'sd77, -16'sd62, -16'sd102, -16'sd109, 16'sd51};
        v_neg5 = '{-16'sd5, -16'sd5, -16'sd5, -16'sd5, -16'sd5, -16'sd5, -16'sd5, -16'sd5};
        v_ext  = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh7FFF};
        v_tie  = '{16'sd3, 16'sd9, 16'sd9, 16'sd1, 16'sd9, 16'sd0, 16'sd0, 16'sd0};
        v_part = '{16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        v_six  = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd7, 16'sd0};

        reset        = 1'b0;
        input_valid  = 1'b0;
        input_data   = 16'sd0;
        output_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_output_valid", {31'd0, output_valid}, 32'sd0);
        chk("reset_input_ready", {31'd0, input_ready}, 32'sd1);
        chk("reset_output_idx", {29'd0, output_idx}, 32'sd0);
`ifdef FC_ARGMAX_VALUE_EN
        chk("reset_output_max", 32'(output_max), 32'sd0);
`endif
        reset = 1'b1;

        // Test 1: back-to-back vector, result on cycle 9
        push_exp(3'd1, 16'sd105);
        send_vec(v1, 8, 1'b0, edges);
        chk("t1_edges", edges, 32'sd8);
        chk("t1_latency_valid", {31'd0, output_valid}, 32'sd1);
        @(posedge clk); #1;

        // Test 2: all-equal and full-range extremes
        push_exp(3'd0, -16'sd5);
        send_vec(v_neg5, 8, 1'b0, edges);
        @(posedge clk); #1;
        push_exp(3'd7, 16'sh7FFF);
        send_vec(v_ext, 8, 1'b0, edges);
        @(posedge clk); #1;

        // Test 3: ties keep lowest index, then the same vector with bubbles
        push_exp(3'd1, 16'sd9);
        send_vec(v_tie, 8, 1'b0, edges);
        @(posedge clk); #1;
        push_exp(3'd1, 16'sd9);
        send_vec(v_tie, 8, 1'b1, edges);
        chk("t3_bubble_edges", edges, 32'sd15);
        chk("t3_bubble_valid", {31'd0, output_valid}, 32'sd1);
        @(posedge clk); #1;

        // Test 4: backpressure holds the result and blocks input
        output_ready = 1'b0;
        push_exp(3'd1, 16'sd9);
        send_vec(v_tie, 8, 1'b0, edges);
        input_valid = 1'b1;
        input_data  = 16'sd50;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", {31'd0, output_valid}, 32'sd1);
            chk("t4_hold_idx", {29'd0, output_idx}, 32'sd1);
            chk("t4_hold_ready", {31'd0, input_ready}, 32'sd0);
        end
        output_ready = 1'b1;
        @(posedge clk); #1;
        input_valid = 1'b0;
        chk("t4_ready_after_accept", {31'd0, input_ready}, 32'sd1);
        chk("t4_valid_after_accept", {31'd0, output_valid}, 32'sd0);

        // Test 6: two vectors streamed, second one stalls exactly one cycle
        push_exp(3'd1, 16'sd105);
        send_vec(v1, 8, 1'b0, edges);
        chk("t6_first_edges", edges, 32'sd8);
        push_exp(3'd6, 16'sd7);
        send_vec(v_six, 8, 1'b0, edges);
        chk("t6_second_edges", edges, 32'sd9);
        @(posedge clk); #1;

        // Test 5: reset mid-vector discards the partial vector
        send_vec(v_part, 4, 1'b0, edges);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t5_reset_valid", {31'd0, output_valid}, 32'sd0);
        chk("t5_reset_ready", {31'd0, input_ready}, 32'sd1);
        chk("t5_reset_idx", {29'd0, output_idx}, 32'sd0);
        reset = 1'b1;
        push_exp(3'd6, 16'sd7);
        send_vec(v_six, 8, 1'b0, edges);
        chk("t5_edges", edges, 32'sd8);

        for (int w = 0; w < 50 && sb_q.size() != 0; w++) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_drained", sb_q.size(), 32'sd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
